branch_resolve_stage: RTL
=========================

# branch_resolve_stage

Registered branch-resolution stage for the RV32I datapath. It sits directly downstream of the 32-bit magnitude comparator. It consumes `rs1 >= rs2` (unsigned) comparisons, builds signed, unsigned and equality outcomes for all six conditional branches plus JAL/JALR, and computes the redirect target. Results are delivered one cycle later through a valid/ready handshake to the PC-select/fetch logic. The block also keeps wrap-around statistics counters for retired control-flow instructions.

## Interface
Parameters:
- `XLEN`, 32: datapath width; only 32 is supported.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream holds a control-flow op.
- `in_ready`  out  1  stage can accept; `= !out_valid || out_ready`.
- `in_pc`  in  32  PC of the instruction.
- `in_rs1`, `in_rs2`  in  32 each  register operands.
- `in_imm`  in  32  sign-extended B/J/I immediate.
- `in_funct3`  in  3  branch condition code.
- `in_op`  in  2  00 = conditional branch, 01 = JAL, 10 = JALR, 11 = reserved (treated as illegal).
- `flush`  in  1  kill the held result and any same-cycle capture.
- `out_valid`  out  1  result register holds a valid result.
- `out_ready`  in  1  downstream consumes the result when `out_valid & out_ready`.
- `out_taken`  out  1  redirect required.
- `out_target`  out  32  redirect PC.
- `out_link`  out  32  `in_pc + 4`, the rd value for JAL/JALR.
- `out_misaligned`  out  1  taken, and `target[1:0] != 0`.
- `out_illegal`  out  1  funct3 ∈ {010, 011} with op = 00, or op = 11.
- `br_count`  out  32  conditional branches retired.
- `taken_count`  out  32  conditional branches retired taken.

## Operation
- Compare primitives, evaluated combinationally on input operands:
  - `geu = (rs1 >= rs2)` unsigned.
  - `ge` = the same comparison with bit 31 of both operands inverted (signed ≥).
  - `eq = (rs1 == rs2)`.
- Condition by funct3:
  - 000 BEQ = `eq`; 001 BNE = `!eq`.
  - 100 BLT = `!ge`; 101 BGE = `ge`.
  - 110 BLTU = `!geu`; 111 BGEU = `geu`.
  - 010/011 → not taken, `out_illegal = 1`.
- JAL and JALR are always taken; funct3 is ignored for both.
- Targets (all additions are modulo 2^32; carry-out is discarded):
  - Branch and JAL: `pc + imm`.
  - JALR: `(rs1 + imm) & ~1`.
- `out_target` is always driven, even when not taken.
- `out_misaligned` is asserted only if `out_taken` and `target[1] = 1`; target bit 0 is already 0 in every case.
- Illegal ops: `out_taken = 0`, `out_misaligned = 0`, counters untouched.
- Output register:
  - Captures on `in_valid & in_ready & !flush`.
  - Holds all `out_*` stable while `out_valid & !out_ready`.
  - `out_valid` clears on handshake with no new capture.
- Flush:
  - Takes priority over everything: next `out_valid = 0`, no capture, no counter update that cycle.
  - The counters also skip a handshake that coincides with flush.
- Counters:
  - Update on the output handshake `out_valid & out_ready & !flush`, and only for legal conditional branches.
  - `br_count` increments by 1 on such a handshake.
  - `taken_count` additionally increments if `out_taken`.
  - Both wrap from `0xFFFFFFFF` to 0.
- Simultaneous handshake and capture: the old result retires (counted), the new result loads, and `out_valid` stays 1.

## Timing
- Latency: 1 cycle. An op accepted at edge N is visible on `out_*` after edge N.
- Throughput: 1 op/cycle while `out_ready = 1`.
- `in_ready` is combinational from `out_valid` and `out_ready`; there is no combinational path from `in_*` to `out_*`.
- Reset (async assert; release takes effect at the next clock edge): `out_valid = 0`, `out_taken = 0`, `out_target = 0`, `out_link = 0`, `out_misaligned = 0`, `out_illegal = 0`, `br_count = 0`, `taken_count = 0`.
- Reset mid-stall discards the held result; the counters are not incremented for it.
- The two-state control is `EMPTY` (`out_valid = 0`) and `FULL` (`out_valid = 1`):
  - EMPTY → FULL on capture.
  - FULL → EMPTY on handshake without capture, or on flush.
  - FULL → FULL on stall, or on handshake plus capture.

## Test plan
- BLT signed vs BLTU: rs1 = 0xFFFFFFFF, rs2 = 0x00000001, pc = 0x100, imm = 0x20.
  - funct3 = 100 → `out_taken = 1`, `target = 0x120`.
  - funct3 = 110 → `out_taken = 0`.
- Equality and boundary: rs1 = rs2 = 0x80000000.
  - BEQ, BGE and BGEU taken; BNE, BLT and BLTU not taken.
  - `br_count` = 6 and `taken_count` = 3 after all six retire.
- JALR: rs1 = 0x1003, imm = 0x0, pc = 0x40 → `out_target = 0x1002`, `out_link = 0x44`, `out_misaligned = 1`, counters unchanged.
- Backpressure: 3 back-to-back BEQ-taken ops with `out_ready` low for 2 cycles.
  - Required: `in_ready = 0` while FULL and stalled, outputs stable, all 3 results delivered in order.
  - Counters end at br = 3, taken = 3.
- Flush and illegal:
  - Flush asserted with `in_valid = 1` while FULL → next cycle `out_valid = 0`, no count.
  - funct3 = 010 → `out_illegal = 1`, `out_taken = 0`.
- Wrap and reset:
  - Preload 0xFFFFFFFF retired branches via stimulus shortcut (force), retire one more → `br_count = 0`.
  - Assert `rst` mid-stall → all outputs 0 immediately.

Source files
------------

// File: rtl/branch_resolve_stage.sv
// Branch resolution stage: branch/jump condition, redirect target and link.
// One-entry registered output with valid/ready and retire statistics.
module branch_resolve_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_op,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_link,
  output logic            out_misaligned,
  output logic            out_illegal,
  output logic [31:0]     br_count,
  output logic [31:0]     taken_count
);

  localparam logic [1:0] OP_BR   = 2'b00;
  localparam logic [1:0] OP_JAL  = 2'b01;
  localparam logic [1:0] OP_JALR = 2'b10;

  localparam logic [2:0] F_BEQ  = 3'b000;
  localparam logic [2:0] F_BNE  = 3'b001;
  localparam logic [2:0] F_BLT  = 3'b100;
  localparam logic [2:0] F_BGE  = 3'b101;
  localparam logic [2:0] F_BLTU = 3'b110;
  localparam logic [2:0] F_BGEU = 3'b111;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic            geu;
  logic            ge;
  logic            eq;
  logic            cond;
  logic            illegal;
  logic            is_br;
  logic            taken;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link;
  logic            misaligned;

  logic            capture;
  logic            retire;

  logic            taken_q;
  logic [XLEN-1:0] target_q;
  logic [XLEN-1:0] link_q;
  logic            mis_q;
  logic            ill_q;
  logic            is_br_q;
  logic [31:0]     br_q;
  logic [31:0]     tk_q;

  // Signed compare reuses the unsigned comparator with sign bits flipped.
  assign geu = (in_rs1 >= in_rs2);
  assign ge  = ({~in_rs1[XLEN-1], in_rs1[XLEN-2:0]} >=
                {~in_rs2[XLEN-1], in_rs2[XLEN-2:0]});
  assign eq  = (in_rs1 == in_rs2);

  // Select the branch condition from funct3.
  always_comb begin
    cond = 1'b0;
    unique case (in_funct3)
      F_BEQ:   cond = eq;
      F_BNE:   cond = !eq;
      F_BLT:   cond = !ge;
      F_BGE:   cond = ge;
      F_BLTU:  cond = !geu;
      F_BGEU:  cond = geu;
      default: cond = 1'b0;
    endcase
  end

  // Classify the op: legal branch, jump, or illegal encoding.
  always_comb begin
    illegal = 1'b0;
    is_br   = 1'b0;
    taken   = 1'b0;
    unique case (in_op)
      OP_BR: begin
        illegal = (in_funct3[2:1] == 2'b01);
        is_br   = !illegal;
        taken   = cond && !illegal;
      end
      OP_JAL, OP_JALR: begin
        taken = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // Redirect target, link value and alignment check.
  always_comb begin
    br_target  = in_pc + in_imm;
    jalr_sum   = in_rs1 + in_imm;
    link       = in_pc + XLEN'(4);
    target     = br_target;
    if (in_op == OP_JALR) begin
      target = {jalr_sum[XLEN-1:1], 1'b0};
    end
    misaligned = taken && target[1];
  end

  assign capture = in_valid && in_ready && !flush;
  assign retire  = out_valid && out_ready && !flush;

  // State register for the single output slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: flush empties, capture fills, lone handshake drains.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (capture) state_d = FULL;
        end
        FULL: begin
          if (capture)        state_d = FULL;
          else if (out_ready) state_d = EMPTY;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    out_valid = (state_q == FULL);
    in_ready  = !out_valid || out_ready;
  end

  // Result register loads only on an accepted, unflushed op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_q  <= 1'b0;
      target_q <= '0;
      link_q   <= '0;
      mis_q    <= 1'b0;
      ill_q    <= 1'b0;
      is_br_q  <= 1'b0;
    end else if (capture) begin
      taken_q  <= taken;
      target_q <= target;
      link_q   <= link;
      mis_q    <= misaligned;
      ill_q    <= illegal;
      is_br_q  <= is_br;
    end
  end

  // Retire counters: legal conditional branches only, wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_q <= '0;
      tk_q <= '0;
    end else if (retire && is_br_q) begin
      br_q <= br_q + 32'd1;
      if (taken_q) begin
        tk_q <= tk_q + 32'd1;
      end
    end
  end

  assign out_taken      = taken_q;
  assign out_target     = target_q;
  assign out_link       = link_q;
  assign out_misaligned = mis_q;
  assign out_illegal    = ill_q;
  assign br_count       = br_q;
  assign taken_count    = tk_q;

endmodule
